div_nonrest: RTL

Iterative unsigned non-restoring divider for the BKM FPU datapath. It produces one quotient bit per clock, reusing the two's-complement adder/subtractor to alternately subtract and add back the divisor. It accepts operands over a valid/ready handshake and holds the quotient and remainder until the consumer takes them. It serves the normalisation and range-reduction stages that need integer division without a combinational array.

---
 rtl/div_nonrest_pkg.sv | 24 ++
 rtl/add_subb.sv | 27 ++
 rtl/div_nonrest.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/div_nonrest_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_nonrest_pkg
// Brief    : Shared FPU divider types: FSM state encoding and latency constants.
// Revision : 1.0 - initial release
// ============================================================================
package div_nonrest_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_CORR = 2'd2,
        ST_DONE = 2'd3
    } div_state_t;

    localparam int DIV_W   = 16;
    localparam int DIV_LAT = DIV_W + 2;

    function automatic int div_cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/add_subb.sv
`default_nettype none
// ============================================================================
// Module   : add_subb
// Brief    : Two's-complement adder/subtractor; each operand may be negated.
// Revision : 1.0 - initial release
// ============================================================================
module add_subb #(
    parameter int WIDTH = 17
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             subb_a,
    input  logic             subb_b,
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH-1:0] w_a_op;
    logic [WIDTH-1:0] w_b_op;

    assign w_a_op = subb_a ? ~a : a;
    assign w_b_op = subb_b ? ~b : b;

    // Negation is invert-plus-one; the carry-out falls off the top.
    assign sum = w_a_op + w_b_op + WIDTH'(subb_a) + WIDTH'(subb_b);

endmodule
`default_nettype wire

// File: rtl/div_nonrest.sv
`default_nettype none
// ============================================================================
// Module   : div_nonrest
// Brief    : Iterative unsigned non-restoring divider, one quotient bit/cycle.
// Revision : 1.0 - initial release
// ============================================================================
module div_nonrest
    import div_nonrest_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] c_last = CW'(W - 1);

    div_state_t     r_state;
    div_state_t     w_state_nxt;
    logic           r_rdy_en;
    logic [W:0]     r_r;
    logic [W-1:0]   r_q;
    logic [W-1:0]   r_d;
    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   r_quotient;
    logic [W-1:0]   r_remainder;
    logic           r_dbz;

    logic           w_accept;
    logic [W:0]     w_r_shift;
    logic [W:0]     w_add_a;
    logic [W:0]     w_add_b;
    logic           w_subb_b;
    logic [W:0]     w_sum;

    assign w_r_shift = {r_r[W-1:0], r_q[W-1]};
    assign w_add_a   = (r_state == ST_CORR) ? r_r : w_r_shift;
    assign w_add_b   = {1'b0, r_d};
    // Sign of the partial remainder picks subtract (non-negative) or add-back.
    assign w_subb_b  = (r_state == ST_CALC) ? ~r_r[W] : 1'b0;

    add_subb #(
        .WIDTH (W + 1)
    ) u_add_subb (
        .a      (w_add_a),
        .b      (w_add_b),
        .subb_a (1'b0),
        .subb_b (w_subb_b),
        .sum    (w_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_rdy_en <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rdy_en <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = r_rdy_en;
                if (r_rdy_en && in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (divisor == '0) ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (r_cnt == c_last) begin
                    w_state_nxt = ST_CORR;
                end
            end
            ST_CORR: begin
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_r         <= '0;
            r_q         <= '0;
            r_d         <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (divisor == '0) begin
                            r_quotient  <= '1;
                            r_remainder <= dividend;
                            r_dbz       <= 1'b1;
                        end else begin
                            r_r   <= '0;
                            r_q   <= dividend;
                            r_d   <= divisor;
                            r_cnt <= '0;
                        end
                    end
                end
                ST_CALC: begin
                    r_r   <= w_sum;
                    r_q   <= {r_q[W-2:0], ~w_sum[W]};
                    r_cnt <= r_cnt + CW'(1);
                end
                ST_CORR: begin
                    r_quotient  <= r_q;
                    r_remainder <= r_r[W] ? w_sum[W-1:0] : r_r[W-1:0];
                    r_dbz       <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire
